// File: rtl/lsu.sv
// Load/store unit: turns one core load/store request into a single memory
// transaction, sizes and replicates store data across byte lanes, and
// extracts/extends the returned lane for loads. One access in flight at a time.
module lsu (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] lane_s;
  logic [31:0] load_data_s;

  // Request legality: supported funct3 encoding and natural alignment.
  always_comb begin
    legal_s = 1'b0;
    case (lsu_size_i)
      3'd0, 3'd4: legal_s = 1'b1;
      3'd1, 3'd5: legal_s = (lsu_addr_i[0] == 1'b0);
      3'd2:       legal_s = (lsu_addr_i[1:0] == 2'b00);
      default:    legal_s = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'd0;
    case (lsu_size_i[1:0])
      2'd0: begin
        be_s    = 4'b0001 << lsu_addr_i[1:0];
        wdata_s = {4{lsu_wdata_i[7:0]}};
      end
      2'd1: begin
        be_s    = 4'b0011 << lsu_addr_i[1:0];
        wdata_s = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = lsu_wdata_i;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it by the latched size.
  always_comb begin
    lane_s      = mem_rdata_i >> {off_q, 3'b000};
    load_data_s = 32'd0;
    case (size_q)
      3'd0:    load_data_s = {{24{lane_s[7]}}, lane_s[7:0]};
      3'd1:    load_data_s = {{16{lane_s[15]}}, lane_s[15:0]};
      3'd2:    load_data_s = mem_rdata_i;
      3'd4:    load_data_s = {24'd0, lane_s[7:0]};
      3'd5:    load_data_s = {16'd0, lane_s[15:0]};
      default: load_data_s = 32'd0;
    endcase
  end

  // Next-state and capture logic; everything holds unless a transition fires.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && legal_s) begin
          state_d     = BUSY;
          size_d      = lsu_size_i;
          off_d       = lsu_addr_i[1:0];
          mem_we_d    = lsu_we_i;
          mem_be_d    = be_s;
          mem_addr_d  = {lsu_addr_i[31:2], 2'b00};
          mem_wdata_d = wdata_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = DONE;
          rdata_d = mem_we_q ? 32'd0 : load_data_s;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured request registers; reset wins over any in-flight ack.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= 3'd0;
      off_q       <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_req_o   = (state_q == BUSY);
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign lsu_rdata_o = rdata_q;

  // Stall covers the request cycle and the whole memory wait; error flags only fresh requests.
  assign lsu_stall_o = ((state_q == IDLE) && lsu_req_i && legal_s) || (state_q == BUSY);
  assign lsu_err_o   = (state_q == IDLE) && lsu_req_i && !legal_s;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected load results go into a scoreboard
// queue when a request is driven and are popped when the access completes.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        issue_stall;
    logic        issue_err;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          req_cycles;
    logic        stable;
    logic        busy_stall;
    logic        done_stall;
    logic        done_req;
    logic [31:0] rdata;
  } obs_t;

  lsu dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .lsu_req_i   (lsu_req_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_size_i  (lsu_size_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_rdata_o (lsu_rdata_o),
    .lsu_stall_o (lsu_stall_o),
    .lsu_err_o   (lsu_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Drives one request (cycle 0), scrambles lsu_* inputs during BUSY, acks at
  // cycle k and returns what was observed; leaves the bench in the DONE cycle.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mrdata, input int k,
                        output obs_t o);
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_wdata_i = wdata;
    #1;
    o.issue_stall = lsu_stall_o;
    o.issue_err   = lsu_err_o;
    o.req_cycles  = 0;
    o.stable      = 1'b1;
    o.busy_stall  = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk_i);
      lsu_req_i = 1'b0; lsu_we_i = ~we; lsu_size_i = 3'd1; lsu_addr_i = ~addr; lsu_wdata_i = 32'hFFFF_FFFF;
      #1;
      if (i == 1) begin
        o.be = mem_be_o; o.addr = mem_addr_o; o.we = mem_we_o; o.wdata = mem_wdata_o;
      end else if (mem_be_o !== o.be || mem_addr_o !== o.addr || mem_we_o !== o.we || mem_wdata_o !== o.wdata) begin
        o.stable = 1'b0;
      end
      if (mem_req_o === 1'b1) o.req_cycles++;
      o.busy_stall = o.busy_stall & lsu_stall_o;
      if (i == k) begin
        mem_ack_i = 1'b1; mem_rdata_i = mrdata;
      end
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    #1;
    o.done_stall = lsu_stall_o;
    o.done_req   = mem_req_o;
    o.rdata      = lsu_rdata_o;
  endtask

  task automatic test_reset();
    reset = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0; lsu_addr_i = 32'd0;
    lsu_wdata_i = 32'd0; mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_rdata_o} !== 70'd0) begin
      fails++; $display("FAIL reset_outputs: got req=%0b we=%0b be=%b addr=%h wdata=%h rdata=%h, want all zero",
                        mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_rdata_o);
    end
    checks++;
    if (lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0) begin
      fails++; $display("FAIL reset_idle_flags: got stall=%0b err=%0b, want 0 0", lsu_stall_o, lsu_err_o);
    end
  endtask

  task automatic test_lw();
    obs_t o;
    sb_q.push_back(32'hDEAD_BEEF);
    access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 3, o);
    checks++;
    if (o.issue_stall !== 1'b1 || o.issue_err !== 1'b0) begin
      fails++; $display("FAIL lw_issue: got stall=%0b err=%0b, want 1 0", o.issue_stall, o.issue_err);
    end
    checks++;
    if (o.req_cycles != 3 || o.done_req !== 1'b0) begin
      fails++; $display("FAIL lw_req_cycles: got %0d busy cycles, done_req=%0b, want 3 and 0", o.req_cycles, o.done_req);
    end
    checks++;
    if (o.be !== 4'b1111 || o.addr !== 32'h100 || o.we !== 1'b0 || o.stable !== 1'b1) begin
      fails++; $display("FAIL lw_mem: got be=%b addr=%h we=%0b stable=%0b, want 1111 00000100 0 1", o.be, o.addr, o.we, o.stable);
    end
    checks++;
    if (o.busy_stall !== 1'b1 || o.done_stall !== 1'b0) begin
      fails++; $display("FAIL lw_stall: got busy=%0b done=%0b, want 1 0", o.busy_stall, o.done_stall);
    end
    checks++;
    if (o.rdata !== sb_q.pop_front()) begin
      fails++; $display("FAIL lw_rdata: got %h, want deadbeef", o.rdata);
    end
  endtask

  task automatic test_byte_half_loads();
    obs_t o;
    logic [2:0]  sz[4]    = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad[4]    = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [3:0]  be_x[4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    logic [31:0] res_x[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_8012};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(res_x[i]);
      access(1'b0, sz[i], ad[i], 32'd0, 32'h8012_3456, 1 + i, o);
      checks++;
      if (o.be !== be_x[i] || o.addr !== 32'h100) begin
        fails++; $display("FAIL load%0d_mem: got be=%b addr=%h, want %b 00000100", i, o.be, o.addr, be_x[i]);
      end
      checks++;
      if (o.rdata !== sb_q.pop_front()) begin
        fails++; $display("FAIL load%0d_rdata: got %h, want %h", i, o.rdata, res_x[i]);
      end
    end
  endtask

  task automatic test_stores();
    obs_t o;
    sb_q.push_back(32'd0);
    access(1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 2, o);
    checks++;
    if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hABCD_ABCD || o.addr !== 32'h200 || o.stable !== 1'b1) begin
      fails++; $display("FAIL sh_mem: got we=%0b be=%b wdata=%h addr=%h stable=%0b, want 1 1100 abcdabcd 00000200 1",
                        o.we, o.be, o.wdata, o.addr, o.stable);
    end
    checks++;
    if (o.rdata !== sb_q.pop_front()) begin
      fails++; $display("FAIL sh_rdata: got %h, want 00000000", o.rdata);
    end
    sb_q.push_back(32'd0);
    access(1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'h2222_2222, 1, o);
    checks++;
    if (o.be !== 4'b0010 || o.wdata !== 32'h7878_7878 || o.rdata !== sb_q.pop_front()) begin
      fails++; $display("FAIL sb: got be=%b wdata=%h rdata=%h, want 0010 78787878 00000000", o.be, o.wdata, o.rdata);
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  sz[3] = '{3'd2, 3'd3, 3'd5};
    logic [31:0] ad[3] = '{32'h101, 32'h100, 32'h103};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = sz[i]; lsu_addr_i = ad[i];
      #1;
      checks++;
      if (lsu_err_o !== 1'b1 || lsu_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
        fails++; $display("FAIL illegal%0d_issue: got err=%0b stall=%0b req=%0b, want 1 0 0", i, lsu_err_o, lsu_stall_o, mem_req_o);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || lsu_err_o !== 1'b1) begin
        fails++; $display("FAIL illegal%0d_stay_idle: got req=%0b err=%0b, want 0 1", i, mem_req_o, lsu_err_o);
      end
    end
    lsu_req_i = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      fails++; $display("FAIL rst_busy_entry: got req=%0b, want 1", mem_req_o);
    end
    reset = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    reset = 1'b0; mem_ack_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || lsu_rdata_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_be_o !== 4'd0 || lsu_stall_o !== 1'b0) begin
      fails++; $display("FAIL rst_busy_outputs: got req=%0b rdata=%h addr=%h be=%b stall=%0b, want 0 0 0 0 0",
                        mem_req_o, lsu_rdata_o, mem_addr_o, mem_be_o, lsu_stall_o);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || lsu_rdata_o !== 32'd0 || lsu_stall_o !== 1'b0 || mem_addr_o !== 32'd0) begin
      fails++; $display("FAIL stray_ack: got req=%0b rdata=%h stall=%0b addr=%h, want 0 0 0 0",
                        mem_req_o, lsu_rdata_o, lsu_stall_o, mem_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    sb_q.push_back(32'h0000_F00D);
    access(1'b0, 3'd5, 32'h0, 32'd0, 32'h0000_F00D, 1, o);
    checks++;
    if (o.rdata !== sb_q.pop_front() || o.done_stall !== 1'b0 || o.req_cycles != 1) begin
      fails++; $display("FAIL b2b_lhu: got rdata=%h stall=%0b req_cycles=%0d, want 0000f00d 0 1", o.rdata, o.done_stall, o.req_cycles);
    end
    // Core advanced in DONE and now presents the SW.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'd2; lsu_addr_i = 32'h10; lsu_wdata_i = 32'h5A5A_0FF0;
    sb_q.push_back(32'd0);
    #1;
    checks++;
    if (lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0 || mem_req_o !== 1'b0) begin
      fails++; $display("FAIL b2b_done_cycle: got stall=%0b err=%0b req=%0b, want 0 0 0", lsu_stall_o, lsu_err_o, mem_req_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || lsu_stall_o !== 1'b1) begin
      fails++; $display("FAIL b2b_sw_issue: got req=%0b stall=%0b, want 0 1", mem_req_o, lsu_stall_o);
    end
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_be_o !== 4'b1111 || mem_wdata_o !== 32'h5A5A_0FF0) begin
      fails++; $display("FAIL b2b_sw_busy: got req=%0b we=%0b addr=%h be=%b wdata=%h, want 1 1 00000010 1111 5a5a0ff0",
                        mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (lsu_rdata_o !== sb_q.pop_front() || lsu_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      fails++; $display("FAIL b2b_sw_done: got rdata=%h stall=%0b req=%0b, want 00000000 0 0", lsu_rdata_o, lsu_stall_o, mem_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_illegal();
    test_lw();
    test_reset_mid_busy();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk_i.
REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock
- reset  in  1  sync active-high reset
- lsu_req_i  in  1  load/store request from core
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  3  funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- lsu_addr_i  in  32  byte address from ALU
- lsu_wdata_i  in  32  store data, from register-file second read port
- lsu_rdata_o  out  32  extended load result, to register-file write-data port
- lsu_stall_o  out  1  core must hold pipeline
- lsu_err_o  out  1  misaligned or illegal-size request
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address
- mem_wdata_o  out  32  lane-replicated store data
- mem_rdata_i  in  32  memory read word
- mem_ack_i  in  1  memory completion, single-cycle pulse

Function
REQ-003 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE -> BUSY on lsu_req_i with a legal request.
- BUSY -> DONE on mem_ack_i.
- DONE -> IDLE unconditionally.
REQ-004 A request SHALL be legal when lsu_size_i is in {0,1,2,4,5} and it is aligned.
- LH/LHU: addr[0]=0.
- LW: addr[1:0]=0.
- Bytes: always aligned.
REQ-005 lsu_err_o SHALL be combinational, equal to lsu_req_i & ~legal in IDLE, and 0 in BUSY/DONE.
- An illegal request SHALL cause no state change, no memory access and no stall.
REQ-006 lsu_stall_o SHALL equal (IDLE & lsu_req_i & legal) | BUSY, combinationally.
- It SHALL be 0 in DONE.
REQ-007 On the IDLE->BUSY edge, the registered outputs SHALL be captured as follows:
- mem_addr_o = {addr[31:2],2'b00}
- mem_we_o = lsu_we_i
- mem_be_o and mem_wdata_o per REQ-008
REQ-008 Byte enables and write data by size (off = addr[1:0]):
- Byte: be = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
- Half: be = 4'b0011 << off; wdata = {2{wdata[15:0]}}.
- Word: be = 4'b1111; wdata = wdata.
- Loads also drive be.
REQ-009 mem_req_o SHALL be 1 exactly while in BUSY.
- All mem_* outputs SHALL stay stable throughout BUSY.
REQ-010 On a load, on the BUSY->DONE edge, lsu_rdata_o SHALL register the selected lane of mem_rdata_i, selected by the latched offset.
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: word unchanged.
REQ-011 On a store, on the BUSY->DONE edge, lsu_rdata_o SHALL be set to 0.
REQ-012 lsu_rdata_o SHALL hold its value in IDLE and DONE until the next completion.
REQ-013 Latency: with a request at cycle 0 and ack at cycle k (k>=1), the block SHALL behave as follows:
- mem_req_o is high cycles 1..k.
- DONE is in cycle k+1.
- Stall is low in cycle k+1, so the core's writeback edge at the end of k+1 uses valid lsu_rdata_o.
REQ-014 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-015 Changes on lsu_* inputs during BUSY SHALL be ignored; latched values are used.
REQ-016 In DONE, a still-asserted lsu_req_i SHALL NOT start a new access.
- The next access starts only from IDLE, one cycle later.
- The core advances on the DONE cycle, so a held request is a new instruction.

Reset
REQ-017 When reset is high at a clock edge, the block SHALL enter IDLE regardless of state, including mid-BUSY.
- Outputs: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, lsu_rdata_o=0.
- Reset SHALL take priority over a simultaneous mem_ack_i.
REQ-018 After reset, lsu_stall_o and lsu_err_o SHALL follow their combinational definitions from IDLE.

Verification
REQ-019 LW:
- Stimulus: addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req.
- Response: mem_req_o high 3 cycles, be=1111, addr 0x100; rdata_o=0xDEADBEEF in DONE; stall low only in DONE.
REQ-020 LB, LBU:
- Stimulus: addr=0x103, mem_rdata=0x80123456.
- Response: LB -> 0xFFFFFF80; LBU -> 0x00000080; be=1000.
REQ-021 SH:
- Stimulus: addr=0x202, wdata=0x0000ABCD.
- Response: mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD, addr 0x200; lsu_rdata_o=0 after completion.
REQ-022 Misaligned LW and illegal size:
- Stimulus: LW at addr=0x101; then size=3.
- Response: lsu_err_o=1 the same cycle; stall=0; mem_req_o stays 0; state stays IDLE.
REQ-023 Reset mid-BUSY:
- Stimulus: reset asserted mid-BUSY, with ack in the same cycle.
- Response: next cycle IDLE, mem_req_o=0, lsu_rdata_o=0; a later ack with no request leaves all outputs unchanged.
REQ-024 Back-to-back:
- Stimulus: LHU at 0x0 with ack in cycle 1, then SW; rdata 0x0000F00D.
- Response: LHU result 0x0000F00D in DONE; SW issues the cycle after DONE.
